// File: rtl/irin_pkg.sv
// rtl/irin_pkg.sv - shared event, key-code and FSM state definitions for the IR key event stage
package irin_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;

    localparam logic [7:0] NO_KEY = 8'h00;

    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_SWAP    = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0] ev_type;
        logic [7:0] code;
    } event_t;

endpackage

// File: rtl/irin_evfifo.sv
// rtl/irin_evfifo.sv - synchronous event queue; a push into a full queue is dropped unless a pop frees a slot
module irin_evfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             push_drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign push_drop_o = push_i && full_o && !do_pop;
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/irin_keyevent.sv
// rtl/irin_keyevent.sv - turns decoded IR codes and line activity into queued PRESS/RELEASE key events
// Defining IRIN_KEYEVENT_REPEAT_EN adds periodic REPEAT events while a key is held.
module irin_keyevent
    import irin_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_MS    = 150,
    parameter int REPEAT_MS  = 110,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code,
    input  logic       ir,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic [1:0] event_type,
    output logic       key_down,
    output logic [7:0] key_code,
    output logic       overflow,
    input  logic       overflow_clr
);
    localparam int TW     = $clog2(TICK_DIV);
    localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int CW     = $clog2(MS_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_MS);

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [7:0]    code_meta_q, code_sync_q, code_prev_q;
    logic          ir_meta_q, ir_sync_q, ir_prev_q;
    logic          ir_edge, code_new, timeout, rep_fire;
    state_e        state_q;
    logic [7:0]    last_code_q, key_code_q;
    logic          key_down_q, overflow_q;
    logic [CW-1:0] hold_cnt_q;
    logic          ev_push;
    event_t        ev_data, head;
    logic          fifo_empty, push_drop, unused_fifo_full;

    assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign code_new = (code_sync_q == code_prev_q) && (code_sync_q != last_code_q);
    assign ir_edge  = ir_sync_q ^ ir_prev_q;
    // An IR edge landing on the expiring tick keeps the key alive.
    assign timeout  = tick && (hold_cnt_q <= CW'(1)) && !ir_edge;

`ifdef IRIN_KEYEVENT_REPEAT_EN
    localparam logic [CW-1:0] REP_LOAD = CW'(REPEAT_MS);
    logic [CW-1:0] rep_cnt_q;
    assign rep_fire = tick && (rep_cnt_q <= CW'(1));
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            code_meta_q <= NO_KEY;
            code_sync_q <= NO_KEY;
            code_prev_q <= NO_KEY;
            ir_meta_q   <= 1'b1;
            ir_sync_q   <= 1'b1;
            ir_prev_q   <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + TW'(1);
            code_meta_q <= code;
            code_sync_q <= code_meta_q;
            code_prev_q <= code_sync_q;
            ir_meta_q   <= ir;
            ir_sync_q   <= ir_meta_q;
            ir_prev_q   <= ir_sync_q;
            overflow_q  <= push_drop | (overflow_q & ~overflow_clr);
        end
    end

    always_comb begin
        ev_push         = 1'b0;
        ev_data.ev_type = EV_PRESS;
        ev_data.code    = NO_KEY;
        case (state_q)
            ST_IDLE: begin
                if (code_new && (code_sync_q != NO_KEY)) begin
                    ev_push      = 1'b1;
                    ev_data.code = code_sync_q;
                end
            end
            ST_PRESSED: begin
                if ((code_new && (code_sync_q != NO_KEY)) || timeout) begin
                    ev_push         = 1'b1;
                    ev_data.ev_type = EV_RELEASE;
                    ev_data.code    = key_code_q;
                end else if (rep_fire) begin
                    ev_push         = 1'b1;
                    ev_data.ev_type = EV_REPEAT;
                    ev_data.code    = key_code_q;
                end
            end
            ST_SWAP: begin
                ev_push      = 1'b1;
                ev_data.code = last_code_q;
            end
            default: ;
        endcase
    end

    // last_code is captured on entry to SWAP so the follow-up PRESS cannot see a third code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_code_q <= NO_KEY;
            key_code_q  <= NO_KEY;
            key_down_q  <= 1'b0;
            hold_cnt_q  <= '0;
`ifdef IRIN_KEYEVENT_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (code_new) begin
                        last_code_q <= code_sync_q;
                        if (code_sync_q != NO_KEY) begin
                            key_code_q <= code_sync_q;
                            key_down_q <= 1'b1;
                            hold_cnt_q <= HOLD_LOAD;
`ifdef IRIN_KEYEVENT_REPEAT_EN
                            rep_cnt_q  <= REP_LOAD;
`endif
                            state_q    <= ST_PRESSED;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (code_new && (code_sync_q != NO_KEY)) begin
                        last_code_q <= code_sync_q;
                        state_q     <= ST_SWAP;
                    end else if (timeout) begin
                        key_down_q <= 1'b0;
                        key_code_q <= NO_KEY;
                        state_q    <= ST_IDLE;
                    end else begin
                        if (ir_edge) begin
                            hold_cnt_q <= HOLD_LOAD;
                        end else if (tick) begin
                            hold_cnt_q <= hold_cnt_q - CW'(1);
                        end
`ifdef IRIN_KEYEVENT_REPEAT_EN
                        if (tick) begin
                            rep_cnt_q <= rep_fire ? REP_LOAD : rep_cnt_q - CW'(1);
                        end
`endif
                    end
                end
                ST_SWAP: begin
                    key_code_q <= last_code_q;
                    hold_cnt_q <= HOLD_LOAD;
`ifdef IRIN_KEYEVENT_REPEAT_EN
                    rep_cnt_q  <= REP_LOAD;
`endif
                    state_q    <= ST_PRESSED;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    irin_evfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_evfifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ev_push),
        .push_data_i (ev_data),
        .pop_i       (event_ready),
        .head_o      (head),
        .full_o      (unused_fifo_full),
        .empty_o     (fifo_empty),
        .push_drop_o (push_drop)
    );

    assign event_valid = !fifo_empty;
    assign event_code  = head.code;
    assign event_type  = head.ev_type;
    assign key_down    = key_down_q;
    assign key_code    = key_code_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_irin_keyevent.sv
// tb/tb_irin_keyevent.sv - directed vector table plus hand sequences for irin_keyevent
module tb_irin_keyevent;
    import irin_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code = 8'h00;
    logic       ir = 1'b1;
    logic       event_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       event_valid, key_down, overflow;
    logic [7:0] event_code, key_code;
    logic [1:0] event_type;

    int checks = 0;
    int passes = 0;
    int rep_seen = 0;

    irin_keyevent #(
        .TICK_DIV   (10),
        .HOLD_MS    (5),
        .REPEAT_MS  (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code         (code),
        .ir           (ir),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_code   (event_code),
        .event_type   (event_type),
        .key_down     (key_down),
        .key_code     (key_code),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && event_valid && event_ready && event_type == EV_REPEAT) rep_seen++;
    end

    typedef struct {
        logic [7:0] code;
        int         wait_n;
        logic       pop;
        logic       exp_valid;
        logic [1:0] exp_type;
        logic [7:0] exp_code;
        logic       exp_down;
        logic [7:0] exp_key;
    } vec_t;

    vec_t vecs[7];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic pop1();
        event_ready = 1'b1;
        step(1);
        event_ready = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [1:0] t, input logic [7:0] c);
        chk({name, " valid"}, event_valid, 1'b1);
        chk({name, " type"}, event_type, t);
        chk({name, " code"}, event_code, c);
    endtask

    // Waits for a non-REPEAT head, discarding any REPEAT events ahead of it.
    task automatic wait_ev(input string name, input int max, output int n);
        n = 0;
        while (n < max && !(event_valid && event_type != EV_REPEAT)) begin
            event_ready = event_valid;
            step(1);
            n++;
        end
        event_ready = 1'b0;
        chk({name, " arrived"}, event_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        int rep_before;

        vecs[0] = '{8'h45, 3, 1'b0, 1'b0, EV_PRESS,   8'h00, 1'b0, 8'h00};
        vecs[1] = '{8'h45, 1, 1'b1, 1'b1, EV_PRESS,   8'h45, 1'b1, 8'h45};
        vecs[2] = '{8'h16, 4, 1'b1, 1'b1, EV_RELEASE, 8'h45, 1'b1, 8'h45};
        vecs[3] = '{8'h16, 0, 1'b1, 1'b1, EV_PRESS,   8'h16, 1'b1, 8'h16};
        vecs[4] = '{8'h16, 1, 1'b0, 1'b0, EV_PRESS,   8'h00, 1'b1, 8'h16};
        vecs[5] = '{8'h00, 5, 1'b0, 1'b0, EV_PRESS,   8'h00, 1'b1, 8'h16};
        vecs[6] = '{8'h16, 5, 1'b0, 1'b0, EV_PRESS,   8'h00, 1'b1, 8'h16};

        step(3);
        chk("reset event_valid", event_valid, 1'b0);
        chk("reset key_down", key_down, 1'b0);
        chk("reset key_code", key_code, 8'h00);
        chk("reset overflow", overflow, 1'b0);
        rst_n = 1'b1;
        step(3);
        chk("post-reset event_valid", event_valid, 1'b0);
        chk("post-reset event_type", event_type, 2'b00);

        for (int i = 0; i < 7; i++) begin
            code = vecs[i].code;
            step(vecs[i].wait_n);
            chk($sformatf("vec%0d valid", i), event_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d type", i), event_type, vecs[i].exp_type);
                chk($sformatf("vec%0d code", i), event_code, vecs[i].exp_code);
            end
            chk($sformatf("vec%0d key_down", i), key_down, vecs[i].exp_down);
            chk($sformatf("vec%0d key_code", i), key_code, vecs[i].exp_key);
            if (vecs[i].pop) pop1();
        end

        // Auto-release after HOLD_MS with no IR activity.
        wait_ev("timeout release", 70, n);
        chk_range("timeout release delay", n, 25, 42);
        chk_head("timeout release", EV_RELEASE, 8'h16);
        chk("timeout key_down", key_down, 1'b0);
        chk("timeout key_code", key_code, 8'h00);
        pop1();

        // Held by IR frames every 30 clk.
        code = 8'h00;
        step(6);
        code = 8'h45;
        wait_ev("hold press", 10, n);
        chk("press latency", n, 4);
        chk_head("hold press", EV_PRESS, 8'h45);
        pop1();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            ir = ~ir;
            repeat (30) begin
                event_ready = event_valid && (event_type == EV_REPEAT);
                step(1);
                if (event_valid && event_type != EV_REPEAT) seen++;
            end
        end
        event_ready = 1'b0;
        chk("no release while ir active", seen, 0);
        chk("held key_down", key_down, 1'b1);
        wait_ev("hold release", 40, n);
        chk_range("release after last edge", n + 30, 42, 55);
        chk_head("hold release", EV_RELEASE, 8'h45);
        pop1();

        // Backpressure: five events into a four-deep queue.
        code = 8'h00;
        step(6);
        code = 8'h45;
        step(6);
        code = 8'h16;
        step(6);
        code = 8'h45;
        step(4);
        chk("queue full no drop yet", overflow, 1'b0);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("drop beats clear", overflow, 1'b1);
        chk("swap key_code", key_code, 8'h45);
        step(2);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("overflow cleared", overflow, 1'b0);
        chk_head("drain0", EV_PRESS, 8'h45);
        pop1();
        chk_head("drain1", EV_RELEASE, 8'h45);
        pop1();
        chk_head("drain2", EV_PRESS, 8'h16);
        pop1();
        chk_head("drain3", EV_RELEASE, 8'h16);
        pop1();
        chk("drained empty", event_valid, 1'b0);
        wait_ev("backpressure release", 70, n);
        chk_head("backpressure release", EV_RELEASE, 8'h45);
        pop1();

        // Key held with IR edges every 20 clk: REPEAT only when the feature is built.
        code = 8'h00;
        step(6);
        event_ready = 1'b1;
        rep_before = rep_seen;
        code = 8'h45;
        for (int i = 0; i < 6; i++) begin
            step(20);
            ir = ~ir;
        end
        chk("repeat window key_down", key_down, 1'b1);
        chk("repeat window key_code", key_code, 8'h45);
`ifdef IRIN_KEYEVENT_REPEAT_EN
        chk_range("repeat events", rep_seen - rep_before, 3, 4);
`else
        chk("repeat events", rep_seen - rep_before, 0);
`endif
        n = 0;
        while (key_down && n < 80) begin
            step(1);
            n++;
        end
        chk("repeat window release", key_down, 1'b0);
        step(2);
        event_ready = 1'b0;
        chk("repeat window empty", event_valid, 1'b0);

        // Reset with events queued.
        code = 8'h00;
        step(6);
        code = 8'h16;
        step(6);
        code = 8'h45;
        step(6);
        pop1();
        chk("pre-reset queued", event_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset event_valid", event_valid, 1'b0);
        chk("async reset key_down", key_down, 1'b0);
        chk("async reset key_code", key_code, 8'h00);
        code = 8'h00;
        step(3);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step(1);
            if (event_valid) seen++;
        end
        chk("no events after reset", seen, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
